// File: rtl/ex_operand_stage.sv
// ex_operand_stage
//   ID/EX register stage directly in front of the ALU. Accepts one decoded
//   instruction per valid/ready handshake, selects the two ALU operands
//   (register file, PC or immediate, optionally with EX/MEM and WB
//   forwarding) and presents them from registers so the ALU inputs are
//   glitch-free. SUB is turned into an add by pre-negating operand2.
//
//   Optional feature: define EX_OPSTAGE_FWD_EN to build the forwarding
//   muxes. Without it src1/src2 come straight from rs1_data/rs2_data and
//   the fwd_* ports are accepted but ignored.
//
// Ports
//   clk, rst                 rising-edge clock, async active-high reset
//   in_valid / in_ready      handshake from decode (in_ready is combinational)
//   flush                    kill held and incoming instruction
//   rs1_addr, rs2_addr       source indices (forwarding compare)
//   rs1_data, rs2_data       register file read data
//   pc, imm                  instruction PC and sign-extended immediate
//   op_a_sel, op_b_sel       operand1: 0=rs1 1=pc ; operand2: 0=rs2 1=imm
//   is_rtype, funct3, funct7 instruction decode fields
//   rd_addr                  destination index
//   fwd_mem_*, fwd_wb_*      EX/MEM and WB write-back bypass sources
//   out_valid / out_ready    handshake toward the EX stage
//   operand1, operand2       ALU operands
//   alu_op3, alu_op7         ALU function codes
//   ex_rd_addr               destination passed down the pipe

module ex_operand_stage #(
  parameter int WIDTH      = 32,
  parameter int REG_ADDR_W = 5
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic                  flush,
  input  logic [REG_ADDR_W-1:0] rs1_addr,
  input  logic [REG_ADDR_W-1:0] rs2_addr,
  input  logic [WIDTH-1:0]      rs1_data,
  input  logic [WIDTH-1:0]      rs2_data,
  input  logic [WIDTH-1:0]      pc,
  input  logic [WIDTH-1:0]      imm,
  input  logic                  op_a_sel,
  input  logic                  op_b_sel,
  input  logic                  is_rtype,
  input  logic [2:0]            funct3,
  input  logic [6:0]            funct7,
  input  logic [REG_ADDR_W-1:0] rd_addr,
  input  logic                  fwd_mem_we,
  input  logic [REG_ADDR_W-1:0] fwd_mem_rd,
  input  logic [WIDTH-1:0]      fwd_mem_data,
  input  logic                  fwd_wb_we,
  input  logic [REG_ADDR_W-1:0] fwd_wb_rd,
  input  logic [WIDTH-1:0]      fwd_wb_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [WIDTH-1:0]      operand1,
  output logic [WIDTH-1:0]      operand2,
  output logic [2:0]            alu_op3,
  output logic [6:0]            alu_op7,
  output logic [REG_ADDR_W-1:0] ex_rd_addr
);

  // Two's-complement negate, wrapping modulo 2^WIDTH (most negative value
  // maps to itself).
  function automatic logic [WIDTH-1:0] negate(input logic [WIDTH-1:0] v);
    logic signed [WIDTH-1:0] neg;
    neg = -$signed(v);
    return $unsigned(neg);
  endfunction

  // Bypass select for one source. MEM is newer than WB, so it wins; x0 is
  // hard-wired zero in the RF and must never be forwarded.
  function automatic logic [WIDTH-1:0] fwd_select(
    input logic [REG_ADDR_W-1:0] src,
    input logic [WIDTH-1:0]      rf,
    input logic                  mem_we,
    input logic [REG_ADDR_W-1:0] mem_rd,
    input logic [WIDTH-1:0]      mem_data,
    input logic                  wb_we,
    input logic [REG_ADDR_W-1:0] wb_rd,
    input logic [WIDTH-1:0]      wb_data
  );
    if (src != '0 && mem_we && mem_rd == src)
      return mem_data;
    else if (src != '0 && wb_we && wb_rd == src)
      return wb_data;
    else
      return rf;
  endfunction

  logic                  capture;
  logic [WIDTH-1:0]      src1_p0;
  logic [WIDTH-1:0]      src2_p0;
  logic [WIDTH-1:0]      op1_p0;
  logic [WIDTH-1:0]      b_p0;
  logic [WIDTH-1:0]      op2_p0;
  logic [6:0]            op7_p0;
  logic                  is_sub_p0;

  // No skid buffer: a new instruction can only enter when the held one
  // leaves in the same cycle (or nothing is held).
  assign in_ready = !out_valid || out_ready;
  assign capture  = in_valid && in_ready && !flush;

  // ---- decode side (p0): operand selection, combinational ----
`ifdef EX_OPSTAGE_FWD_EN
  assign src1_p0 = fwd_select(rs1_addr, rs1_data, fwd_mem_we, fwd_mem_rd,
                              fwd_mem_data, fwd_wb_we, fwd_wb_rd, fwd_wb_data);
  assign src2_p0 = fwd_select(rs2_addr, rs2_data, fwd_mem_we, fwd_mem_rd,
                              fwd_mem_data, fwd_wb_we, fwd_wb_rd, fwd_wb_data);
`else
  assign src1_p0 = rs1_data;
  assign src2_p0 = rs2_data;

  // Forwarding ports stay on the boundary for integration but are unused.
  logic unused_fwd;
  assign unused_fwd = ^{rs1_addr, rs2_addr, fwd_mem_we, fwd_mem_rd,
                        fwd_mem_data, fwd_wb_we, fwd_wb_rd, fwd_wb_data};
`endif

  always_comb begin
    op1_p0    = op_a_sel ? pc  : src1_p0;
    b_p0      = op_b_sel ? imm : src2_p0;
    // ALU only adds on funct3=000, so SUB is realised as a + (-b).
    is_sub_p0 = is_rtype && (funct3 == 3'b000) && funct7[5];
    op2_p0    = is_sub_p0 ? negate(b_p0) : b_p0;
    // I-type shifts carry their funct7-equivalent in imm[11:5] (SRAI sets
    // bit 5); other I-type ops must present zero so the ALU does not
    // mistake them for SUB/SRA.
    if (is_rtype)
      op7_p0 = funct7;
    else if (funct3 == 3'b101)
      op7_p0 = imm[11:5];
    else
      op7_p0 = 7'b0;
  end

  // ---- EX boundary (p1): registered ALU inputs ----
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0;
    end else if (flush) begin
      out_valid <= 1'b0;
    end else if (capture) begin
      out_valid <= 1'b1;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

  // Data only moves on capture, so a stall freezes it and forwarding
  // sources are not re-sampled. After flush/completion stale values remain.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      operand1   <= '0;
      operand2   <= '0;
      alu_op3    <= '0;
      alu_op7    <= '0;
      ex_rd_addr <= '0;
    end else if (capture) begin
      operand1   <= op1_p0;
      operand2   <= op2_p0;
      alu_op3    <= funct3;
      alu_op7    <= op7_p0;
      ex_rd_addr <= rd_addr;
    end
  end

endmodule
